// File: rtl/envelope_generator.sv
// ---------------------------------------------------------------------------
// envelope_generator
//   Per-voice ADSR envelope for the 8-voice square synthesizer. Gate events
//   move a voice between IDLE/ATTACK/DECAY/SUSTAIN/RELEASE. Each env_tick
//   starts a sweep that updates one voice per clock (voice i at tick edge
//   + 1 + i), so a sweep lasts exactly N_VOICES cycles.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   env_tick          one-cycle pulse starting an update sweep
//   event_valid       gate event strobe
//   event_voice       voice index of the event
//   event_gate        1 = note on, 0 = note off
//   attack_rate       level increment per tick in ATTACK
//   decay_rate        level decrement per tick in DECAY
//   sustain_level     SUSTAIN target, clamped to LEVEL_MAX
//   release_rate      level decrement per tick in RELEASE
//   voice_volumes     registered level per voice
//   voice_active      bit i set while voice i is not IDLE
//   busy              high while a sweep is in progress
//   tick_overrun      one-cycle pulse when env_tick arrives while busy
// ---------------------------------------------------------------------------
module envelope_generator #(
  parameter int unsigned N_VOICES  = 8,
  parameter int unsigned LEVEL_MAX = 65536
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         env_tick,
  input  logic                         event_valid,
  input  logic [2:0]                   event_voice,
  input  logic                         event_gate,
  input  logic [31:0]                  attack_rate,
  input  logic [31:0]                  decay_rate,
  input  logic [31:0]                  sustain_level,
  input  logic [31:0]                  release_rate,
  output logic [N_VOICES-1:0][31:0]    voice_volumes,
  output logic [N_VOICES-1:0]          voice_active,
  output logic                         busy,
  output logic                         tick_overrun
);

  typedef enum logic [2:0] {
    V_IDLE,
    V_ATTACK,
    V_DECAY,
    V_SUSTAIN,
    V_RELEASE
  } voice_state_e;

  localparam logic [32:0] LMAX33 = 33'(LEVEL_MAX);

  voice_state_e state_q [N_VOICES];
  voice_state_e state_d [N_VOICES];
  logic [31:0]  level_q [N_VOICES];
  logic [31:0]  level_d [N_VOICES];

  logic         busy_q, busy_d;
  logic [2:0]   idx_q, idx_d;
  logic         overrun_q, overrun_d;

  logic [32:0]  sus33;

  // Sustain target clamped to full scale; 33 bits so sums below cannot wrap.
  always_comb begin
    if ({1'b0, sustain_level} > LMAX33) begin
      sus33 = LMAX33;
    end else begin
      sus33 = {1'b0, sustain_level};
    end
  end

  // Sweep sequencer: ticks arriving mid-sweep are dropped and flagged.
  always_comb begin
    busy_d    = busy_q;
    idx_d     = idx_q;
    overrun_d = env_tick && busy_q;
    if (busy_q) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'(N_VOICES - 1)) begin
        busy_d = 1'b0;
      end
    end else if (env_tick) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end
  end

  // Per-voice next state. The gate event is applied first, then the level
  // rule of the resulting state, so an event landing on the voice being
  // updated steers that same update.
  always_comb begin : voice_next
    voice_state_e st;
    logic [32:0]  lv;
    for (int unsigned i = 0; i < N_VOICES; i++) begin
      st = state_q[i];
      lv = {1'b0, level_q[i]};

      if (event_valid && (event_voice == 3'(i))) begin
        if (event_gate) begin
          st = V_ATTACK;
        end else if (st == V_ATTACK || st == V_DECAY || st == V_SUSTAIN) begin
          st = V_RELEASE;
        end
      end

      if (busy_q && (idx_q == 3'(i))) begin
        case (st)
          V_IDLE: begin
            lv = '0;
          end
          V_ATTACK: begin
            if (lv + {1'b0, attack_rate} >= LMAX33) begin
              lv = LMAX33;
              st = V_DECAY;
            end else begin
              lv = lv + {1'b0, attack_rate};
            end
          end
          V_DECAY: begin
            if (lv <= sus33 + {1'b0, decay_rate}) begin
              lv = sus33;
              st = V_SUSTAIN;
            end else begin
              lv = lv - {1'b0, decay_rate};
            end
          end
          V_SUSTAIN: begin
            lv = sus33;
          end
          V_RELEASE: begin
            if (lv <= {1'b0, release_rate}) begin
              lv = '0;
              st = V_IDLE;
            end else begin
              lv = lv - {1'b0, release_rate};
            end
          end
          default: begin
            lv = '0;
            st = V_IDLE;
          end
        endcase
      end

      state_d[i] = st;
      level_d[i] = lv[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_VOICES; i++) begin
        state_q[i] <= V_IDLE;
        level_q[i] <= '0;
      end
      busy_q    <= 1'b0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_VOICES; i++) begin
        state_q[i] <= state_d[i];
        level_q[i] <= level_d[i];
      end
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_VOICES; i++) begin
      voice_volumes[i] = level_q[i];
      voice_active[i]  = (state_q[i] != V_IDLE);
    end
  end

  assign busy         = busy_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_envelope_generator.sv
// ---------------------------------------------------------------------------
// tb_envelope_generator
//   Directed ADSR scenarios followed by randomized ticks, gate events, rate
//   changes and resets. A behavioural model tracks each voice by phase name
//   and integer level; the sweep is modelled by the edge number at which the
//   accepted tick arrived (voice k is updated k+1 edges later).
// ---------------------------------------------------------------------------
module tb_envelope_generator;

  localparam longint LMAX = 65536;
  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             env_tick;
  logic             event_valid;
  logic [2:0]       event_voice;
  logic             event_gate;
  logic [31:0]      attack_rate, decay_rate, sustain_level, release_rate;
  logic [7:0][31:0] voice_volumes;
  logic [7:0]       voice_active;
  logic             busy;
  logic             tick_overrun;

  envelope_generator #(.N_VOICES(8), .LEVEL_MAX(65536)) dut (
    .clk           (clk),
    .reset         (reset),
    .env_tick      (env_tick),
    .event_valid   (event_valid),
    .event_voice   (event_voice),
    .event_gate    (event_gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .voice_volumes (voice_volumes),
    .voice_active  (voice_active),
    .busy          (busy),
    .tick_overrun  (tick_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_phase [8];
  longint m_level [8];
  longint m_edge  = 0;
  longint m_start = -1000;   // edge at which the current sweep's tick was taken
  bit     m_over  = 1'b0;

  function automatic bit m_busy();
    return (m_edge - m_start) >= 0 && (m_edge - m_start) <= 7;
  endfunction

  task automatic m_update(input int v);
    longint s;
    s = sustain_level;
    if (s > LMAX) s = LMAX;
    case (m_phase[v])
      P_IDLE: m_level[v] = 0;
      P_ATK: begin
        if (m_level[v] + longint'(attack_rate) >= LMAX) begin
          m_level[v] = LMAX;
          m_phase[v] = P_DEC;
        end else m_level[v] += attack_rate;
      end
      P_DEC: begin
        if (m_level[v] <= s + longint'(decay_rate)) begin
          m_level[v] = s;
          m_phase[v] = P_SUS;
        end else m_level[v] -= decay_rate;
      end
      P_SUS: m_level[v] = s;
      default: begin
        if (m_level[v] <= longint'(release_rate)) begin
          m_level[v] = 0;
          m_phase[v] = P_IDLE;
        end else m_level[v] -= release_rate;
      end
    endcase
  endtask

  always @(posedge clk) begin
    bit     was_busy;
    longint k;
    was_busy = m_busy();
    m_edge++;
    if (reset) begin
      for (int v = 0; v < 8; v++) begin
        m_phase[v] = P_IDLE;
        m_level[v] = 0;
      end
      m_start = -1000;
      m_over  = 1'b0;
    end else begin
      m_over = env_tick && was_busy;
      if (event_valid) begin
        if (event_gate) m_phase[event_voice] = P_ATK;
        else if (m_phase[event_voice] != P_IDLE) m_phase[event_voice] = P_REL;
      end
      k = m_edge - m_start - 1;
      if (k >= 0 && k <= 7) m_update(int'(k));
      if (env_tick && !was_busy) m_start = m_edge;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_all();
    for (int v = 0; v < 8; v++) begin
      check_eq($sformatf("vol[%0d]", v), voice_volumes[v], m_level[v]);
    end
    for (int v = 0; v < 8; v++) begin
      check_eq($sformatf("active[%0d]", v), voice_active[v], m_phase[v] != P_IDLE);
    end
    check_eq("busy", busy, m_busy());
    check_eq("overrun", tick_overrun, m_over);
  endtask

  // Drive one cycle's inputs (already past a negedge), sample at the next negedge.
  task automatic cycle(input bit tk, input bit ev, input int v, input bit g);
    env_tick    = tk;
    event_valid = ev;
    event_voice = 3'(v);
    event_gate  = g;
    @(negedge clk);
    check_all();
  endtask

  task automatic sweep();
    cycle(1, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick_rate();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'($urandom_range(1, 3000));
      2: return 32'd16384;
      3: return 32'd65536;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_sustain();
    case ($urandom % 4)
      0: return 32'd0;
      1: return 32'd65537;
      2: return 32'hFFFF_FFFF;
      default: return 32'($urandom_range(0, 65536));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    longint atk_seq [9] = '{16384, 32768, 49152, 65536, 57344, 49152, 40960, 32768, 32768};
    int busy_cnt, over_cnt;

    reset = 1'b1;
    env_tick = 0; event_valid = 0; event_voice = 0; event_gate = 0;
    attack_rate = 0; decay_rate = 0; sustain_level = 0; release_rate = 0;
    repeat (3) cycle(0, 0, 0, 0);
    check_eq("rst_active", voice_active, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;

    // Idle ticks leave everything silent.
    repeat (20) sweep();
    for (int v = 0; v < 8; v++) check_eq($sformatf("idle_vol[%0d]", v), voice_volumes[v], 0);
    check_eq("idle_active", voice_active, 0);

    // Attack / decay / sustain on voice 3.
    attack_rate = 16384; decay_rate = 8192; sustain_level = 32768; release_rate = 4096;
    cycle(0, 1, 3, 1);
    for (int k = 0; k < 9; k++) begin
      sweep();
      check_eq($sformatf("ads[%0d]", k), voice_volumes[3], atk_seq[k]);
      check_eq($sformatf("ads_other[%0d]", k), voice_volumes[2], 0);
    end

    // Release from sustain.
    cycle(0, 1, 3, 0);
    for (int k = 1; k <= 8; k++) begin
      sweep();
      check_eq($sformatf("rel[%0d]", k), voice_volumes[3], 32768 - 4096 * k);
      check_eq($sformatf("rel_act[%0d]", k), voice_active[3], k < 8);
    end

    // Sweep timing and overrun.
    cycle(0, 1, 0, 1);
    cycle(0, 1, 7, 1);
    busy_cnt = 0; over_cnt = 0;
    cycle(1, 0, 0, 0);                      // tick edge T
    busy_cnt += busy;
    cycle(0, 0, 0, 0);                      // edge T+1
    check_eq("t1_v0", voice_volumes[0], 16384);
    check_eq("t1_v7", voice_volumes[7], 0);
    busy_cnt += busy;
    cycle(0, 0, 0, 0);                      // T+2
    busy_cnt += busy;
    cycle(1, 0, 0, 0);                      // T+3: overrun
    busy_cnt += busy; over_cnt += tick_overrun;
    for (int k = 4; k <= 7; k++) begin
      cycle(0, 0, 0, 0);
      busy_cnt += busy; over_cnt += tick_overrun;
    end
    check_eq("t7_v7", voice_volumes[7], 0);
    cycle(0, 0, 0, 0);                      // T+8
    check_eq("t8_v7", voice_volumes[7], 16384);
    busy_cnt += busy;
    check_eq("busy_cycles", busy_cnt, 8);
    check_eq("overrun_pulses", over_cnt, 1);
    repeat (12) cycle(0, 0, 0, 0);
    check_eq("no_extra_sweep", voice_volumes[0], 16384);

    // Retrigger during release keeps the level.
    attack_rate = 20000;
    cycle(0, 1, 5, 1);
    sweep();
    check_eq("retrig_pre", voice_volumes[5], 20000);
    cycle(0, 1, 5, 0);
    attack_rate = 16384;
    cycle(0, 1, 5, 1);
    sweep();
    check_eq("retrig", voice_volumes[5], 36384);

    // Sustain clamp and zero attack from idle.
    sustain_level = 32'hFFFF_FFFF;
    attack_rate = 65536;
    cycle(0, 1, 1, 1);
    sweep();
    check_eq("clamp_peak", voice_volumes[1], 65536);
    attack_rate = 0;
    cycle(0, 1, 2, 1);
    sweep();
    check_eq("clamp_dec", voice_volumes[1], 65536);
    check_eq("zero_atk_vol", voice_volumes[2], 0);
    check_eq("zero_atk_act", voice_active[2], 1);
    sweep();
    check_eq("clamp_hold", voice_volumes[1], 65536);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        attack_rate = pick_rate(); decay_rate = pick_rate();
        release_rate = pick_rate(); sustain_level = pick_sustain();
      end
      reset = ($urandom % 600) == 0;
      cycle(($urandom % 5) == 0, ($urandom % 3) == 0, int'($urandom % 8), 1'($urandom % 2));
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
- Per-voice ADSR envelope stage directly upstream of the 8-voice square synthesizer; drives its 32-bit per-voice volume inputs.
- Takes gate on/off events (from the note/key decoder) and a periodic envelope tick.
- Updates the 8 voices' envelope levels sequentially, one voice per clock, on each tick.

Parameters:
- N_VOICES, 8, number of voices; fixed at 8 to match the synthesizer volume array.
- LEVEL_MAX, 65536, full-scale volume, written as voice_volumes at envelope peak.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- env_tick  in  1  one-cycle pulse that starts an envelope update sweep.
- event_valid  in  1  gate event strobe.
- event_voice  in  3  voice index for the event.
- event_gate  in  1  1 = note on, 0 = note off.
- attack_rate  in  32  level increment per tick in ATTACK.
- decay_rate  in  32  level decrement per tick in DECAY.
- sustain_level  in  32  SUSTAIN target; values above LEVEL_MAX are treated as LEVEL_MAX.
- release_rate  in  32  level decrement per tick in RELEASE.
- voice_volumes  out  32 x [7:0]  current level per voice; connects straight to the synthesizer volume input.
- voice_active  out  8  bit i = 1 when voice i is not IDLE.
- busy  out  1  high while a sweep is in progress.
- tick_overrun  out  1  one-cycle pulse when env_tick arrives while busy.

Behaviour:
- Reset:
  - All levels 0, all voice states IDLE.
  - voice_volumes all 0, voice_active 0, busy 0, tick_overrun 0, sweep index 0.
  - Reset asserted mid-sweep aborts the sweep on that edge.
- Per-voice states: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Gate events, applied on the clock edge where event_valid = 1:
  - Gate on: any state goes to ATTACK. Level is kept, so retrigger is legato with no click.
  - Gate off: ATTACK, DECAY or SUSTAIN go to RELEASE. Ignored in IDLE and RELEASE.
  - An event never changes the level directly.
- Sweep timing:
  - env_tick while not busy: busy goes high next edge; index runs 0..7.
  - Voice i is updated at edge T+1+i, where T is the tick edge. Its new level is visible on voice_volumes[i] from cycle T+1+i onward.
  - busy falls after voice 7, so a sweep occupies exactly 8 cycles.
  - A new tick is accepted on the cycle busy is low.
- Overrun: env_tick while busy is dropped and tick_overrun pulses for 1 cycle.
- Event and update on the same voice and same edge: the state transition from the event takes effect. The level update that edge uses the new state's rule.
- Level update per tick. Compute with 33-bit intermediates so wrap-around is impossible.
  - IDLE: level = 0.
  - ATTACK: if level + attack_rate >= LEVEL_MAX, set level = LEVEL_MAX and go to DECAY; otherwise add attack_rate.
  - DECAY: if level <= S + decay_rate, set level = S and go to SUSTAIN; otherwise subtract decay_rate. S is sustain_level clamped to LEVEL_MAX.
  - SUSTAIN: level = S each tick, so it tracks live sustain_level changes.
  - RELEASE: if level <= release_rate, set level = 0 and go to IDLE; otherwise subtract release_rate.
- Zero rates:
  - A zero rate holds the level in that state indefinitely.
  - Exception: attack_rate = 0 with level = LEVEL_MAX still moves to DECAY, by the >= rule.
- Sustain of 0: DECAY reaches 0 and stays in SUSTAIN. The voice remains active until gate off.
- Rate inputs are sampled at the cycle each voice is updated; no latching per sweep.
- voice_volumes is registered and changes only on update edges or reset.

Test Plan:
- Reset, then 20 ticks with no events -> all voice_volumes = 0, voice_active = 0, no overrun.
- Attack ramp, with attack_rate = 16384, decay_rate = 8192, sustain_level = 32768, release_rate = 4096:
  - Stimulus: gate on voice 3, then ticks.
  - voice_volumes[3] sequence: 16384, 32768, 49152, 65536 (enters DECAY), 57344, 49152, 40960, 32768 (enters SUSTAIN), then holds 32768.
  - Other voices stay 0.
- Release: from that sustain, gate off voice 3 -> 28672, 24576, … each tick. The 8th tick gives 0; voice_active[3] drops on the same edge.
- Timing: tick at cycle T -> voice 0 changes at edge T+1 and voice 7 at edge T+8; busy is high for 8 cycles. A second tick at T+3 -> tick_overrun pulse and no extra sweep.
- Retrigger in RELEASE at level 20000 with attack_rate 16384 -> next tick gives 36384 (no reset to 0).
- Sustain clamp: sustain_level = 0xFFFFFFFF -> DECAY exits immediately at 65536. Attack_rate = 0 from IDLE -> level stays 0 and voice_active = 1.
